// File: rtl/iscas_bist_pkg.sv
// Shared types and constants for the ISCAS s27 BIST engine: FSM states,
// the Galois tap mask and the LFSR seed.
package iscas_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_CMP   = 3'd4
    } bist_state_e;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Galois tap mask
    localparam logic [15:0] POLY_MASK = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] galois_step(input logic [15:0] s);
        return s[0] ? ({1'b0, s[15:1]} ^ POLY_MASK) : {1'b0, s[15:1]};
    endfunction

endpackage

// File: rtl/lfsr_misr16.sv
// 16-bit Galois shift register with load-to-INIT, enable and data-in XOR.
// Serves as the pattern LFSR (din tied 0) and as the response MISR.
module lfsr_misr16
    import iscas_bist_pkg::*;
#(
    parameter logic [15:0] INIT = LFSR_SEED
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] din_i,
    output logic [15:0] q_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i)
            state_d = INIT;
        else if (en_i)
            state_d = galois_step(state_q) ^ din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= INIT;
        else         state_q <= state_d;
    end

    assign q_o = state_q;

endmodule

// File: rtl/iscas_bist_engine.sv
// BIST session controller for an ISCAS s27-style CUT: LFSR stimulus, MISR
// compaction, optional golden compare enabled by macro BIST_GOLDEN_CMP_EN.
module iscas_bist_engine
    import iscas_bist_pkg::*;
#(
    parameter int          PI_W      = 4,
    parameter int          PO_W      = 1,
    parameter int          PAT_CNT   = 255,
    parameter int          FLUSH_CYC = 3,
    parameter logic [15:0] GOLDEN    = 16'h0000
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            START,
    input  logic [PO_W-1:0] CUT_PO,
    output logic [PI_W-1:0] CUT_PI,
    output logic            CUT_EN,
    output logic            BUSY,
    output logic            DONE,
    output logic [15:0]     SIGNATURE,
    output logic            PASS
);

    localparam logic [15:0] PAT_LAST = 16'(PAT_CNT - 1);
    localparam logic [3:0]  FL_LAST  = (FLUSH_CYC == 0) ? 4'd0 : 4'(FLUSH_CYC - 1);

    bist_state_e state_q, state_d;
    logic [15:0] pat_cnt_q, pat_cnt_d;
    logic [3:0]  fl_cnt_q, fl_cnt_d;
    logic [15:0] lfsr_q, misr_q, po_ext;

    always_comb begin
        state_d   = state_q;
        pat_cnt_d = pat_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_SEED;
            ST_SEED: begin
                pat_cnt_d = '0;
                fl_cnt_d  = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                pat_cnt_d = pat_cnt_q + 16'd1;
                if (pat_cnt_q == PAT_LAST)
                    state_d = (FLUSH_CYC == 0) ? ST_CMP : ST_FLUSH;
            end
            ST_FLUSH: begin
                fl_cnt_d = fl_cnt_q + 4'd1;
                if (fl_cnt_q == FL_LAST) state_d = ST_CMP;
            end
            ST_CMP:  if (START) state_d = ST_SEED;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            pat_cnt_q <= '0;
            fl_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pat_cnt_q <= pat_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

    always_comb begin
        po_ext             = '0;
        po_ext[PO_W-1:0]   = CUT_PO;
    end

    lfsr_misr16 #(.INIT(LFSR_SEED)) u_lfsr (
        .clk_i  (CK),
        .rst_ni (RN),
        .en_i   (state_q == ST_RUN),
        .load_i (state_q == ST_SEED),
        .din_i  (16'h0000),
        .q_o    (lfsr_q)
    );

    // MISR keeps compacting through FLUSH to catch the CUT's pipelined responses
    lfsr_misr16 #(.INIT(16'h0000)) u_misr (
        .clk_i  (CK),
        .rst_ni (RN),
        .en_i   ((state_q == ST_RUN) || (state_q == ST_FLUSH)),
        .load_i (state_q == ST_SEED),
        .din_i  (po_ext),
        .q_o    (misr_q)
    );

    assign CUT_PI    = lfsr_q[PI_W-1:0];
    assign CUT_EN    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign BUSY      = (state_q == ST_SEED) || CUT_EN;
    assign DONE      = (state_q == ST_CMP);
    assign SIGNATURE = misr_q;

`ifdef BIST_GOLDEN_CMP_EN
    assign PASS = DONE && (misr_q == GOLDEN);
`else
    assign PASS = 1'b0;
`endif

endmodule
